// File: rtl/jtag_shift_engine_pkg.sv
// Shared definitions for the JTAG shift engine of the AHB3-Lite remote bridge.
package jtag_shift_engine_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } jtag_state_t;

   localparam int JTAG_MAXLEN = 32;

   localparam logic [2:0] DIV2   = 3'd0;
   localparam logic [2:0] DIV4   = 3'd1;
   localparam logic [2:0] DIV8   = 3'd2;
   localparam logic [2:0] DIV16  = 3'd3;
   localparam logic [2:0] DIV32  = 3'd4;
   localparam logic [2:0] DIV64  = 3'd5;
   localparam logic [2:0] DIV128 = 3'd6;
   localparam logic [2:0] DIV256 = 3'd7;

   // Half-period counter reload: 2^div - 1 system clocks.
   function automatic logic [7:0] half_m1(input logic [2:0] div);
      return (8'd1 << div) - 8'd1;
   endfunction

endpackage

// File: rtl/jtag_shift_engine_if.sv
// Bridge-side batch request/response bundle plus the JTAG pins of the shift engine.
interface jtag_shift_engine_if #(parameter int MAXLEN = 32);
   logic [2:0]        DIV;
   logic              START;
   logic [4:0]        LEN_M1;
   logic [MAXLEN-1:0] TMS_DATA;
   logic [MAXLEN-1:0] TDI_DATA;
   logic [MAXLEN-1:0] TDO_DATA;
   logic              BUSY;
   logic              DONE;
   logic              TCK;
   logic              TMS;
   logic              TDI;
   logic              TDO;

   modport master (
      output DIV, START, LEN_M1, TMS_DATA, TDI_DATA, TDO,
      input  TDO_DATA, BUSY, DONE, TCK, TMS, TDI
   );

   modport slave (
      input  DIV, START, LEN_M1, TMS_DATA, TDI_DATA, TDO,
      output TDO_DATA, BUSY, DONE, TCK, TMS, TDI
   );
endinterface

// File: rtl/jtag_shift_engine.sv
// Shifts a batch of 1..32 TMS/TDI bit pairs out on a divided TCK and captures TDO.
//
//   state | meaning
//   IDLE  | TCK low, TMS/TDI hold last values, waiting for START
//   LOW   | TCK low half-period; TMS/TDI for current bit set up
//   HIGH  | TCK high half-period; TDO already captured on the rise
module jtag_shift_engine
   import jtag_shift_engine_pkg::*;
#(
   parameter int MAXLEN = JTAG_MAXLEN
) (
   input  logic                CLKIN,
   input  logic                RESETn,
   jtag_shift_engine_if.slave  bus
);

   jtag_state_t       state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [4:0]        idx_q, idx_d;
   logic [4:0]        len_q, len_d;
   logic [2:0]        div_q, div_d;
   logic [MAXLEN-1:0] tms_sh_q, tms_sh_d;
   logic [MAXLEN-1:0] tdi_sh_q, tdi_sh_d;
   logic [MAXLEN-1:0] tdo_data_q, tdo_data_d;
   logic              tck_q, tck_d;
   logic              tms_q, tms_d;
   logic              tdi_q, tdi_d;
   logic              done_q, done_d;

   always_ff @(posedge CLKIN or negedge RESETn) begin
      if (!RESETn) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         len_q      <= '0;
         div_q      <= '0;
         tms_sh_q   <= '0;
         tdi_sh_q   <= '0;
         tdo_data_q <= '0;
         tck_q      <= 1'b0;
         tms_q      <= 1'b1;
         tdi_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         len_q      <= len_d;
         div_q      <= div_d;
         tms_sh_q   <= tms_sh_d;
         tdi_sh_q   <= tdi_sh_d;
         tdo_data_q <= tdo_data_d;
         tck_q      <= tck_d;
         tms_q      <= tms_d;
         tdi_q      <= tdi_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      len_d      = len_q;
      div_d      = div_q;
      tms_sh_d   = tms_sh_q;
      tdi_sh_d   = tdi_sh_q;
      tdo_data_d = tdo_data_q;
      tck_d      = tck_q;
      tms_d      = tms_q;
      tdi_d      = tdi_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.START) begin
               div_d      = bus.DIV;
               len_d      = bus.LEN_M1;
               tms_d      = bus.TMS_DATA[0];
               tdi_d      = bus.TDI_DATA[0];
               // Bit 0 goes out now; keep the rest pre-shifted so the next bit is always [0].
               tms_sh_d   = bus.TMS_DATA >> 1;
               tdi_sh_d   = bus.TDI_DATA >> 1;
               tdo_data_d = '0;
               idx_d      = '0;
               cnt_d      = half_m1(bus.DIV);
               state_d    = LOW;
            end
         end
         LOW: begin
            if (cnt_q == 8'd0) begin
               tck_d             = 1'b1;
               tdo_data_d[idx_q] = bus.TDO;
               cnt_d             = half_m1(div_q);
               state_d           = HIGH;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         HIGH: begin
            if (cnt_q == 8'd0) begin
               tck_d = 1'b0;
               if (idx_q == len_q) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  idx_d    = idx_q + 5'd1;
                  tms_d    = tms_sh_q[0];
                  tdi_d    = tdi_sh_q[0];
                  tms_sh_d = tms_sh_q >> 1;
                  tdi_sh_d = tdi_sh_q >> 1;
                  cnt_d    = half_m1(div_q);
                  state_d  = LOW;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.TDO_DATA = tdo_data_q;
   assign bus.BUSY     = (state_q != IDLE);
   assign bus.DONE     = done_q;
   assign bus.TCK      = tck_q;
   assign bus.TMS      = tms_q;
   assign bus.TDI      = tdi_q;

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Self-checking bench for jtag_shift_engine: vector table plus scoreboard of per-bit and result expectations.
module tb_jtag_shift_engine;
   import jtag_shift_engine_pkg::*;

   typedef struct {
      logic [2:0]  div;
      logic [4:0]  len;
      logic [31:0] tms;
      logic [31:0] tdi;
      logic [1:0]  mode;      // 0: TDO=0, 1: TDO=1, 2: TDO looped from TDI
      logic [31:0] exp_tdo;
   } vec_t;

   typedef struct {
      int   cyc;
      logic tms;
      logic tdi;
   } bit_exp_t;

   logic       clk;
   logic       rst_n;
   logic [1:0] tdo_mode;
   int         n_chk;
   int         n_pass;
   vec_t       vecs[5];
   bit_exp_t   bit_q[$];
   logic [31:0] res_q[$];

   jtag_shift_engine_if #(.MAXLEN(32)) bus();

   jtag_shift_engine #(.MAXLEN(32)) dut (
      .CLKIN  (clk),
      .RESETn (rst_n),
      .bus    (bus)
   );

   assign bus.TDO = (tdo_mode == 2'd2) ? bus.TDI : tdo_mode[0];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
   endtask

   task automatic run_batch(input vec_t v, input bit disturb);
      int h, n, lat, c, rises, busy_err, extra;
      bit done_seen;
      logic prev_tck;
      bit_exp_t e;
      logic [31:0] r;
      h = 1 << v.div;
      n = int'(v.len) + 1;
      lat = 2 * h * n;
      for (int k = 0; k < n; k++) begin
         e.cyc = h * (2 * k + 1);
         e.tms = v.tms[k];
         e.tdi = v.tdi[k];
         bit_q.push_back(e);
      end
      res_q.push_back(v.exp_tdo);

      @(negedge clk);
      bus.DIV = v.div; bus.LEN_M1 = v.len;
      bus.TMS_DATA = v.tms; bus.TDI_DATA = v.tdi;
      tdo_mode = v.mode; bus.START = 1'b1;
      @(negedge clk);
      // Edge E0 has just happened; scramble the request inputs to prove they were latched.
      bus.START = 1'b0;
      bus.DIV = 3'($urandom); bus.LEN_M1 = 5'($urandom);
      bus.TMS_DATA = $urandom; bus.TDI_DATA = $urandom;
      c = 0; rises = 0; busy_err = 0; done_seen = 1'b0; prev_tck = 1'b0;
      while (!done_seen && c <= lat + 4) begin
         if (bus.TCK && !prev_tck) begin
            rises++;
            if (bit_q.size() == 0) check("rise_unexpected", 32'(rises), 32'(n));
            else begin
               e = bit_q.pop_front();
               check("rise_cycle", 32'(c), 32'(e.cyc));
               check("tms_at_rise", 32'(bus.TMS), 32'(e.tms));
               check("tdi_at_rise", 32'(bus.TDI), 32'(e.tdi));
            end
         end
         if (bus.BUSY !== ((c < lat) ? 1'b1 : 1'b0)) busy_err++;
         if (bus.DONE) begin
            done_seen = 1'b1;
            check("done_cycle", 32'(c), 32'(lat));
            r = res_q.pop_front();
            check("tdo_data", bus.TDO_DATA, r);
         end
         if (disturb && c == 3) begin bus.START = 1'b1; bus.DIV = DIV256; end
         if (disturb && c == 5) bus.START = 1'b0;
         prev_tck = bus.TCK;
         if (!done_seen) begin
            @(negedge clk);
            c++;
         end
      end
      check("done_seen", 32'(done_seen), 32'd1);
      check("rise_count", 32'(rises), 32'(n));
      check("busy_profile_errs", 32'(busy_err), 32'd0);
      extra = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.DONE || bus.BUSY || bus.TCK) extra++;
      end
      check("quiet_after_done", 32'(extra), 32'd0);
      bit_q.delete();
      res_q.delete();
   endtask

   initial begin
      int c, c1, c2, lat, bad;
      vec_t rv;
      n_chk = 0; n_pass = 0;
      vecs[0] = '{div: 3'd0, len: 5'd7,  tms: 32'h0000_0080, tdi: 32'h0000_00A5, mode: 2'd2, exp_tdo: 32'h0000_00A5};
      vecs[1] = '{div: 3'd3, len: 5'd0,  tms: 32'h0000_0000, tdi: 32'h0000_0000, mode: 2'd1, exp_tdo: 32'h0000_0001};
      vecs[2] = '{div: 3'd1, len: 5'd31, tms: 32'h1234_5678, tdi: 32'hDEAD_BEEF, mode: 2'd1, exp_tdo: 32'hFFFF_FFFF};
      vecs[3] = '{div: 3'd2, len: 5'd4,  tms: 32'h0000_0015, tdi: 32'h0000_000A, mode: 2'd0, exp_tdo: 32'h0000_0000};
      vecs[4] = '{div: 3'd0, len: 5'd15, tms: 32'hFFFF_F0F0, tdi: 32'hABCD_1234, mode: 2'd2, exp_tdo: 32'h0000_1234};

      rst_n = 1'b0; tdo_mode = 2'd0;
      bus.DIV = '0; bus.START = 1'b0; bus.LEN_M1 = '0;
      bus.TMS_DATA = '0; bus.TDI_DATA = '0;
      repeat (3) @(negedge clk);
      check("rst_tck", 32'(bus.TCK), 32'd0);
      check("rst_tms", 32'(bus.TMS), 32'd1);
      check("rst_tdi", 32'(bus.TDI), 32'd0);
      check("rst_busy", 32'(bus.BUSY), 32'd0);
      check("rst_done", 32'(bus.DONE), 32'd0);
      check("rst_tdo_data", bus.TDO_DATA, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) run_batch(vecs[i], 1'b0);

      // START pulse and DIV change during a DIV2 4-bit batch must be ignored.
      rv = '{div: 3'd0, len: 5'd3, tms: 32'h0000_0009, tdi: 32'h0000_0006, mode: 2'd2, exp_tdo: 32'h0000_0006};
      run_batch(rv, 1'b1);

      // Asynchronous reset during bit 3 of an 8-bit batch.
      @(negedge clk);
      bus.DIV = 3'd0; bus.LEN_M1 = 5'd7; bus.TMS_DATA = 32'h0; bus.TDI_DATA = 32'hFF;
      tdo_mode = 2'd1; bus.START = 1'b1;
      @(negedge clk);
      bus.START = 1'b0;
      repeat (7) @(negedge clk);
      check("pre_rst_tck", 32'(bus.TCK), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_tck", 32'(bus.TCK), 32'd0);
      check("mid_rst_tms", 32'(bus.TMS), 32'd1);
      check("mid_rst_tdi", 32'(bus.TDI), 32'd0);
      check("mid_rst_busy", 32'(bus.BUSY), 32'd0);
      check("mid_rst_tdo_data", bus.TDO_DATA, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.DONE || bus.BUSY) bad++;
      end
      check("no_done_after_rst", 32'(bad), 32'd0);
      run_batch(vecs[0], 1'b0);

      // Back-to-back: START held, second batch accepted in the DONE cycle.
      lat = 2 * (1 << 7) * 2;
      @(negedge clk);
      bus.DIV = DIV256; bus.LEN_M1 = 5'd1; bus.TMS_DATA = 32'h2; bus.TDI_DATA = 32'h1;
      tdo_mode = 2'd2; bus.START = 1'b1;
      @(negedge clk);
      c = 0; c1 = -1; c2 = -1;
      while (c2 < 0 && c <= 2 * lat + 10) begin
         if (bus.DONE) begin
            if (c1 < 0) begin
               c1 = c;
               check("b2b_busy_in_done", 32'(bus.BUSY), 32'd0);
               check("b2b_tdo_data1", bus.TDO_DATA, 32'h1);
            end else begin
               c2 = c;
               bus.START = 1'b0;
               check("b2b_tdo_data2", bus.TDO_DATA, 32'h1);
            end
         end
         if (c1 >= 0 && c == c1 + 1) check("b2b_busy_restart", 32'(bus.BUSY), 32'd1);
         if (c2 < 0) begin
            @(negedge clk);
            c++;
         end
      end
      bus.START = 1'b0;
      check("b2b_done1_cycle", 32'(c1), 32'(lat));
      check("b2b_done2_cycle", 32'(c2), 32'(2 * lat + 1));
      repeat (3) @(negedge clk);
      check("b2b_idle_after", 32'(bus.BUSY), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
